run_extractor: RTL

Parametrised successor to the single-class run finder. Converts a streamed, class-labelled pixel line into tokens: runs (class, row, start, end), end-of-line and end-of-frame. Adds multi-class labels, a minimum-run-length filter and same-class gap bridging. Output is a valid/ready token FIFO. Sits between the pixel classifier and the blob/centroid tracker.

---
 rtl/run_pkg.sv | 48 ++++
 rtl/run_token_fifo.sv | 77 +++++++
 rtl/run_extractor.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/run_pkg.sv
// Shared definitions for the run extractor: token kinds, run FSM states,
// and token packing helpers used by the extractor and its token FIFO.
package run_pkg;

  localparam logic [1:0] KIND_RUN       = 2'd0;
  localparam logic [1:0] KIND_END_LINE  = 2'd1;
  localparam logic [1:0] KIND_END_FRAME = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IN_RUN = 2'd1,
    GAP    = 2'd2
  } run_state_e;

  // Widest token any legal parameter set can produce; callers truncate.
  localparam int TOK_MAX = 128;

  function automatic int token_width(input int class_w, input int row_w, input int col_w);
    return 2 + class_w + row_w + 2 * col_w;
  endfunction

  function automatic logic [TOK_MAX-1:0] field_bits(input logic [31:0] v, input int w);
    logic [TOK_MAX-1:0] m;
    m = (TOK_MAX'(1) << w) - TOK_MAX'(1);
    return TOK_MAX'(v) & m;
  endfunction

  // Layout, MSB to LSB: kind, class, row, start, end.
  function automatic logic [TOK_MAX-1:0] pack_token(
    input logic [1:0]  kind,
    input logic [31:0] cls,
    input logic [31:0] row,
    input logic [31:0] st,
    input logic [31:0] en,
    input int          class_w,
    input int          row_w,
    input int          col_w
  );
    logic [TOK_MAX-1:0] t;
    t = TOK_MAX'(kind);
    t = (t << class_w) | field_bits(cls, class_w);
    t = (t << row_w)   | field_bits(row, row_w);
    t = (t << col_w)   | field_bits(st, col_w);
    t = (t << col_w)   | field_bits(en, col_w);
    return t;
  endfunction

endpackage

// File: rtl/run_token_fifo.sv
// Show-ahead token FIFO accepting up to three ordered pushes and one pop
// per cycle. Pushes that find no room are dropped and counted.
module run_token_fifo #(
  parameter int TOK_W = 36,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            push_vld_i,
  input  logic [2:0][TOK_W-1:0] push_data_i,
  input  logic                  pop_i,
  output logic                  rd_vld_o,
  output logic [TOK_W-1:0]      rd_data_o,
  output logic [LW-1:0]         level_o,
  output logic [1:0]            drop_cnt_o
);

  localparam int FW = LW + 1;

  logic [AW-1:0]      wptr_q, rptr_q;
  logic [LW-1:0]      level_q;
  logic [TOK_W-1:0]   mem_q [DEPTH];

  logic               pop;
  logic [FW-1:0]      free;
  logic [1:0]         n_acc;
  logic [2:0]         wen;
  logic [2:0][AW-1:0] waddr;

  // Slot allocation: accept valid pushes in order while space remains.
  always_comb begin
    pop        = (level_q != '0) && pop_i;
    free       = FW'(DEPTH) - FW'(level_q) + FW'(pop);
    n_acc      = 2'd0;
    drop_cnt_o = 2'd0;
    wen        = '0;
    waddr      = '0;
    for (int i = 0; i < 3; i++) begin
      if (push_vld_i[i]) begin
        if (FW'(n_acc) < free) begin
          wen[i]   = 1'b1;
          waddr[i] = wptr_q + AW'(n_acc);
          n_acc    = n_acc + 2'd1;
        end else begin
          drop_cnt_o = drop_cnt_o + 2'd1;
        end
      end
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_q + AW'(n_acc);
      rptr_q  <= rptr_q + AW'(pop);
      level_q <= level_q + LW'(n_acc) - LW'(pop);
    end
  end

  // Token storage; contents are only meaningful below the level count.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (wen[i]) mem_q[waddr[i]] <= push_data_i[i];
    end
  end

  assign rd_vld_o  = (level_q != '0);
  assign rd_data_o = mem_q[rptr_q];
  assign level_o   = level_q;

endmodule

// File: rtl/run_extractor.sv
// Converts a class-labelled pixel stream into RUN / END_LINE / END_FRAME
// tokens with minimum-length filtering and same-class gap bridging.
module run_extractor
  import run_pkg::*;
#(
  parameter int COL_W      = 11,
  parameter int ROW_W      = 10,
  parameter int CLASS_W    = 2,
  parameter int MIN_RUN    = 1,
  parameter int MAX_GAP    = 0,
  parameter int FIFO_DEPTH = 8,
  localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               new_pixel,
  input  logic [CLASS_W-1:0] pixel_class,
  input  logic               end_line_in,
  input  logic               end_frame_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [1:0]         out_kind,
  output logic [CLASS_W-1:0] out_class,
  output logic [ROW_W-1:0]   out_row,
  output logic [COL_W-1:0]   out_start,
  output logic [COL_W-1:0]   out_end,
  output logic [LVL_W-1:0]   fifo_level,
  output logic               overflow
);

  localparam int TOK_W = token_width(CLASS_W, ROW_W, COL_W);
  localparam int LEN_W = COL_W + 1;
  localparam int GAP_W = $clog2(MAX_GAP + 1) + 1;
  localparam int O_ST  = COL_W;
  localparam int O_ROW = 2 * COL_W;
  localparam int O_CLS = O_ROW + ROW_W;
  localparam int O_KND = O_CLS + CLASS_W;

  function automatic logic [COL_W-1:0] col_inc(input logic [COL_W-1:0] v);
    return (v == '1) ? v : v + COL_W'(1);
  endfunction

  function automatic logic [ROW_W-1:0] row_inc(input logic [ROW_W-1:0] v);
    return (v == '1) ? v : v + ROW_W'(1);
  endfunction

  run_state_e         state_q, state_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [CLASS_W-1:0] cls_q, cls_d;
  logic [COL_W-1:0]   start_q, start_d;
  logic [COL_W-1:0]   end_q, end_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               overflow_q;

  logic                  close;
  logic [LEN_W-1:0]      run_len;
  logic [2:0]            push_vld;
  logic [2:0][TOK_W-1:0] push_data;
  logic                  rd_vld;
  logic [TOK_W-1:0]      rd_data;
  logic [1:0]            drop_cnt;

  // Run FSM next-state and counters; line/frame events take priority over pixels.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    cls_d   = cls_q;
    start_d = start_q;
    end_d   = end_q;
    gap_d   = gap_q;
    close   = 1'b0;
    if (end_line_in || end_frame_in) begin
      close   = (state_q != IDLE);
      state_d = IDLE;
      col_d   = '0;
      row_d   = end_frame_in ? '0 : row_inc(row_q);
    end else if (new_pixel) begin
      col_d = col_inc(col_q);
      case (state_q)
        IDLE: begin
          if (pixel_class != '0) begin
            state_d = IN_RUN;
            cls_d   = pixel_class;
            start_d = col_q;
            end_d   = col_q;
          end
        end
        IN_RUN, GAP: begin
          if (pixel_class == cls_q) begin
            end_d   = col_q;
            state_d = IN_RUN;
          end else if (pixel_class == '0) begin
            if (state_q == IN_RUN && MAX_GAP > 0) begin
              state_d = GAP;
              gap_d   = GAP_W'(1);
            end else if (state_q == GAP && (int'(gap_q) + 1) <= MAX_GAP) begin
              gap_d = gap_q + GAP_W'(1);
            end else begin
              close   = 1'b1;
              state_d = IDLE;
            end
          end else begin
            close   = 1'b1;
            state_d = IN_RUN;
            cls_d   = pixel_class;
            start_d = col_q;
            end_d   = col_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Token generation in fixed order RUN, END_LINE, END_FRAME.
  always_comb begin
    run_len      = LEN_W'(end_q) - LEN_W'(start_q) + LEN_W'(1);
    push_vld[0]  = close && (run_len >= LEN_W'(MIN_RUN));
    push_vld[1]  = end_line_in;
    push_vld[2]  = end_frame_in;
    push_data[0] = TOK_W'(pack_token(KIND_RUN, 32'(cls_q), 32'(row_q), 32'(start_q),
                                     32'(end_q), CLASS_W, ROW_W, COL_W));
    push_data[1] = TOK_W'(pack_token(KIND_END_LINE, 32'd0, 32'(row_q), 32'd0, 32'd0,
                                     CLASS_W, ROW_W, COL_W));
    push_data[2] = TOK_W'(pack_token(KIND_END_FRAME, 32'd0, 32'(row_q), 32'd0, 32'd0,
                                     CLASS_W, ROW_W, COL_W));
  end

  // Control state; run fields are only consulted while a run is open.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      col_q      <= '0;
      row_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      overflow_q <= overflow_q | (drop_cnt != 2'd0);
    end
  end

  // Open-run attributes.
  always_ff @(posedge clk) begin
    cls_q   <= cls_d;
    start_q <= start_d;
    end_q   <= end_d;
    gap_q   <= gap_d;
  end

  run_token_fifo #(
    .TOK_W (TOK_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_vld_i  (push_vld),
    .push_data_i (push_data),
    .pop_i       (out_ready),
    .rd_vld_o    (rd_vld),
    .rd_data_o   (rd_data),
    .level_o     (fifo_level),
    .drop_cnt_o  (drop_cnt)
  );

  // Output unpacking; data fields read as zero whenever no token is offered.
  always_comb begin
    out_valid = rd_vld;
    out_kind  = '0;
    out_class = '0;
    out_row   = '0;
    out_start = '0;
    out_end   = '0;
    if (rd_vld) begin
      out_kind  = rd_data[O_KND +: 2];
      out_class = rd_data[O_CLS +: CLASS_W];
      out_row   = rd_data[O_ROW +: ROW_W];
      out_start = rd_data[O_ST +: COL_W];
      out_end   = rd_data[0 +: COL_W];
    end
  end

  assign overflow = overflow_q;

endmodule
